// File: rtl/spectrum_packer_pkg.sv
// rtl/spectrum_packer_pkg.sv - shared types, header layout and helpers for the spectrum packer
package spectrum_packer_pkg;

    localparam int DEF_CHANNELS = 2048;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_LANES    = 4;
    localparam int DEF_FIFO_AW  = 11;

    localparam int WORDS_PER_SPEC = DEF_CHANNELS / DEF_LANES;

    localparam logic [7:0] HDR_MAGIC     = 8'hA5;
    localparam int         HDR_MAGIC_LSB = 56;
    localparam int         HDR_OVF_BIT   = 48;
    localparam int         HDR_SEQ_W     = 48;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ADMIT     = 2'd1,
        RUN       = 2'd2,
        DROP      = 2'd3
    } packer_state_t;

    function automatic logic [63:0] make_header(input logic ovf, input logic [HDR_SEQ_W-1:0] seq);
        return {HDR_MAGIC, 7'b0, ovf, seq};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/spectrum_packer_commit_fifo.sv
// rtl/spectrum_packer_commit_fifo.sv - frame FIFO with speculative/committed write pointers and FWFT stream read
module commit_fifo
    import spectrum_packer_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 66
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          reserve,
    input  logic          hdr_en,
    input  logic [AW-1:0] hdr_addr,
    input  logic [DW-1:0] hdr_data,
    input  logic          commit,
    input  logic [AW:0]   commit_ptr,
    input  logic          rollback,
    output logic [AW:0]   wr_ptr,
    output logic [AW:0]   free_words,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]   cwptr;
    logic [AW:0]   rptr;
    logic          load;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;

    // Header and payload writes never coincide, so one write port suffices.
    assign ram_we    = wr_en | hdr_en;
    assign ram_waddr = hdr_en ? hdr_addr : wr_ptr[AW-1:0];
    assign ram_wdata = hdr_en ? hdr_data : wr_data;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // A rollback in the same cycle as a commit must land on the freshly committed end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            cwptr  <= '0;
        end else begin
            if (commit) begin
                cwptr <= commit_ptr;
            end
            if (rollback) begin
                wr_ptr <= commit ? commit_ptr : cwptr;
            end else if (wr_en | reserve) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    assign free_words = DEPTH - (wr_ptr - rptr);
    assign load       = (rptr != cwptr) && (!m_tvalid || m_tready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr     <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else if (load) begin
            m_tdata  <= mem[rptr[AW-1:0]];
            rptr     <= rptr + 1'b1;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/spectrum_packer.sv
// rtl/spectrum_packer.sv - frames requantised spectra into header+payload words; SPECTRUM_OVF_FLAG_EN adds overflow flag
module spectrum_packer
    import spectrum_packer_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int LANES    = DEF_LANES,
    parameter int FIFO_AW  = DEF_FIFO_AW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic                      sync_in,
    input  logic [SAMPLE_W-1:0]       data_in,
    input  logic                      ovf_in,
    output logic [LANES*SAMPLE_W-1:0] m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic                      m_tuser,
    output logic [31:0]               drop_count
);

    localparam int WORDS  = CHANNELS / LANES;
    localparam int CH_W   = $clog2(CHANNELS);
    localparam int LN_W   = $clog2(LANES);
    localparam int BEAT_W = LANES * SAMPLE_W;
    localparam logic [CH_W-1:0]    LAST_CHAN  = CH_W'(CHANNELS - 1);
    localparam logic [LN_W-1:0]    LAST_LANE  = LN_W'(LANES - 1);
    localparam logic [FIFO_AW:0]   ADMIT_NEED = (FIFO_AW+1)'(WORDS + 1);

`ifdef SPECTRUM_OVF_FLAG_EN
    localparam int FW = BEAT_W + 2;
`else
    localparam int FW = BEAT_W + 1;
`endif

    packer_state_t                 state;
    logic [CH_W-1:0]               chan;
    logic [LN_W-1:0]               lane;
    logic [LANES-2:0][SAMPLE_W-1:0] lane_buf;
    logic [HDR_SEQ_W-1:0]          seq;
    logic [HDR_SEQ_W-1:0]          hdr_seq;
    logic [FIFO_AW-1:0]            hdr_ptr;
    logic [FIFO_AW:0]              end_ptr;
    logic                          hdr_pend;
    logic                          commit_pend;
    logic                          hdr_ovf;
    logic                          last_user;

    logic             run_sample;
    logic             abort;
    logic             admit_eval;
    logic             admit_ok;
    logic             take_sample;
    logic             word_done;
    logic             spec_done;
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] free_words;
    logic [FW-1:0]    fifo_wdata;
    logic [FW-1:0]    fifo_hdata;
    logic [FW-1:0]    fifo_tdata;

    assign lane        = chan[LN_W-1:0];
    assign run_sample  = ce && (state == RUN);
    // A sync on the last channel just confirms the natural wrap.
    assign abort       = run_sample && sync_in && (chan != LAST_CHAN);
    assign admit_eval  = ce && (state == ADMIT) && !sync_in;
    assign admit_ok    = free_words >= ADMIT_NEED;
    assign take_sample = (run_sample && !abort) || (admit_eval && admit_ok);
    assign word_done   = take_sample && (lane == LAST_LANE);
    assign spec_done   = run_sample && !abort && (chan == LAST_CHAN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= WAIT_SYNC;
            chan        <= '0;
            lane_buf    <= '0;
            seq         <= '0;
            hdr_seq     <= '0;
            hdr_ptr     <= '0;
            end_ptr     <= '0;
            hdr_pend    <= 1'b0;
            commit_pend <= 1'b0;
            drop_count  <= '0;
        end else begin
            hdr_pend    <= spec_done;
            commit_pend <= hdr_pend;
            if (take_sample && (lane != LAST_LANE)) begin
                lane_buf[lane] <= data_in;
            end
            if (spec_done) begin
                end_ptr <= wr_ptr + 1'b1;
            end
            if (ce) begin
                case (state)
                    WAIT_SYNC: begin
                        if (sync_in) begin
                            state <= ADMIT;
                            chan  <= '0;
                        end
                    end
                    ADMIT: begin
                        if (!sync_in) begin
                            hdr_seq <= seq;
                            seq     <= seq + 1'b1;
                            chan    <= CH_W'(1);
                            if (admit_ok) begin
                                state   <= RUN;
                                hdr_ptr <= wr_ptr[FIFO_AW-1:0];
                            end else begin
                                state      <= DROP;
                                drop_count <= sat_inc(drop_count);
                            end
                        end
                    end
                    RUN: begin
                        if (abort) begin
                            state      <= ADMIT;
                            chan       <= '0;
                            drop_count <= sat_inc(drop_count);
                        end else begin
                            chan <= chan + 1'b1;
                            if (chan == LAST_CHAN) begin
                                state <= ADMIT;
                            end
                        end
                    end
                    DROP: begin
                        if (sync_in || (chan == LAST_CHAN)) begin
                            state <= ADMIT;
                            chan  <= '0;
                        end else begin
                            chan <= chan + 1'b1;
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end
        end
    end

`ifdef SPECTRUM_OVF_FLAG_EN
    logic ovf_acc;

    // Channel 0 arrives in the ADMIT cycle, so its flag seeds the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_acc <= 1'b0;
        end else if (admit_eval) begin
            ovf_acc <= ovf_in;
        end else if (run_sample && !abort) begin
            ovf_acc <= ovf_acc | ovf_in;
        end
    end

    assign hdr_ovf    = ovf_acc;
    assign last_user  = spec_done & (ovf_acc | ovf_in);
    assign fifo_wdata = {last_user, spec_done, data_in, lane_buf};
    assign fifo_hdata = {1'b0, 1'b0, make_header(hdr_ovf, hdr_seq)};
    assign {m_tuser, m_tlast, m_tdata} = fifo_tdata;
`else
    logic unused_ovf;

    assign unused_ovf = ovf_in;
    assign hdr_ovf    = 1'b0;
    assign last_user  = 1'b0;
    assign fifo_wdata = {spec_done, data_in, lane_buf};
    assign fifo_hdata = {1'b0, make_header(hdr_ovf, hdr_seq)};
    assign {m_tlast, m_tdata} = fifo_tdata;
    assign m_tuser    = last_user;
`endif

    commit_fifo #(
        .AW (FIFO_AW),
        .DW (FW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (word_done),
        .wr_data    (fifo_wdata),
        .reserve    (admit_eval && admit_ok),
        .hdr_en     (hdr_pend),
        .hdr_addr   (hdr_ptr),
        .hdr_data   (fifo_hdata),
        .commit     (commit_pend),
        .commit_ptr (end_ptr),
        .rollback   (abort),
        .wr_ptr     (wr_ptr),
        .free_words (free_words),
        .m_tdata    (fifo_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready)
    );

endmodule

// File: tb/tb_spectrum_packer.sv
// tb/tb_spectrum_packer.sv - scoreboard bench for spectrum_packer
module tb_spectrum_packer;
    import spectrum_packer_pkg::*;

    localparam int CH = DEF_CHANNELS;
    localparam int NW = WORDS_PER_SPEC;
`ifdef SPECTRUM_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ce       = 1'b0;
    logic        sync_in  = 1'b0;
    logic        ovf_in   = 1'b0;
    logic        m_tready = 1'b1;
    logic [15:0] data_in  = '0;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic [31:0] drop_count;

    spectrum_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .sync_in    (sync_in),
        .data_in    (data_in),
        .ovf_in     (ovf_in),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [65:0] sb [$];
    int          exp_seq  = 0;
    bit          in_frame = 1'b0;
    bit          prev_stall = 1'b0;
    logic [65:0] prev_beat = '0;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (in_frame) check("tvalid_in_frame", 66'(m_tvalid), 66'(1));
            if (prev_stall) begin
                check("hold_valid", 66'(m_tvalid), 66'(1));
                check("hold_beat", {m_tuser, m_tlast, m_tdata}, prev_beat);
            end
            if (m_tvalid && m_tready) begin
                check("sb_has_entry", 66'(sb.size() != 0), 66'(1));
                if (sb.size() != 0) check("beat", {m_tuser, m_tlast, m_tdata}, sb.pop_front());
                in_frame = !m_tlast;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tuser, m_tlast, m_tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ce      = 1'b0;
        sync_in = 1'b0;
        ovf_in  = 1'b0;
        tick();
        sb.delete();
        exp_seq = 0;
        check("rst_tvalid", 66'(m_tvalid), 66'(0));
        check("rst_tlast", 66'(m_tlast), 66'(0));
        check("rst_tuser", 66'(m_tuser), 66'(0));
        check("rst_tdata", 66'(m_tdata), 66'(0));
        check("rst_drops", 66'(drop_count), 66'(0));
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_sync();
        ce      = 1'b1;
        sync_in = 1'b1;
        data_in = 16'($urandom);
        tick();
        ce      = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic send_spectrum(input bit emit, input bit ramp, input int ovf_chan);
        logic [15:0] smp [CH];
        logic        any_ovf;
        logic        fl;
        any_ovf = 1'b0;
        for (int ch = 0; ch < CH; ch++) begin
            smp[ch] = ramp ? 16'(ch) : 16'($urandom);
            ce      = 1'b1;
            data_in = smp[ch];
            ovf_in  = (ch == ovf_chan);
            if (ch == ovf_chan) any_ovf = 1'b1;
            tick();
        end
        ce     = 1'b0;
        ovf_in = 1'b0;
        if (emit) begin
            fl = any_ovf & OVF_EN;
            sb.push_back({1'b0, 1'b0, 8'hA5, 7'b0, fl, 48'(exp_seq)});
            for (int w = 0; w < NW; w++) begin
                sb.push_back({fl & (w == NW - 1), (w == NW - 1),
                              smp[4*w+3], smp[4*w+2], smp[4*w+1], smp[4*w]});
            end
        end
        exp_seq++;
    endtask

    task automatic send_partial_then_sync(input int n);
        for (int ch = 0; ch < n; ch++) begin
            ce      = 1'b1;
            data_in = 16'($urandom);
            tick();
        end
        ce      = 1'b1;
        sync_in = 1'b1;
        tick();
        ce      = 1'b0;
        sync_in = 1'b0;
        exp_seq++;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 6000) begin
            tick();
            n++;
        end
        check(tag, 66'(sb.size()), 66'(0));
        repeat (8) tick();
        check({tag, "_idle"}, 66'(m_tvalid), 66'(0));
    endtask

    initial begin
        int n;
        do_reset();

        // single ramp spectrum
        send_sync();
        send_spectrum(1'b1, 1'b1, -1);
        wait_drain("t1_drain");
        check("t1_drops", 66'(drop_count), 66'(0));

        // three back-to-back spectra
        do_reset();
        send_sync();
        repeat (3) send_spectrum(1'b1, 1'b0, -1);
        wait_drain("t2_drain");
        check("t2_drops", 66'(drop_count), 66'(0));

        // backpressure: fourth spectrum finds no room
        do_reset();
        m_tready = 1'b0;
        send_sync();
        repeat (3) send_spectrum(1'b1, 1'b0, -1);
        send_spectrum(1'b0, 1'b0, -1);
        check("t3_drops", 66'(drop_count), 66'(1));
        check("t3_stalled_valid", 66'(m_tvalid), 66'(1));
        m_tready = 1'b1;
        wait_drain("t3_drain3");
        send_spectrum(1'b1, 1'b0, -1);
        wait_drain("t3_drain4");
        check("t3_drops_end", 66'(drop_count), 66'(1));

        // overflow flag at channel 7
        do_reset();
        send_sync();
        send_spectrum(1'b1, 1'b0, 7);
        wait_drain("t5_drain");

        // mid-spectrum sync abort
        do_reset();
        send_sync();
        send_partial_then_sync(1000);
        check("t4_drops", 66'(drop_count), 66'(1));
        send_spectrum(1'b1, 1'b0, -1);
        wait_drain("t4_drain");
        check("t4_drops_end", 66'(drop_count), 66'(1));

        // reset while a frame is streaming
        send_spectrum(1'b1, 1'b0, -1);
        n = 0;
        while (!m_tvalid && n < 100) begin
            tick();
            n++;
        end
        check("t6_valid_before_rst", 66'(m_tvalid), 66'(1));
        repeat (20) tick();
        do_reset();
        send_sync();
        send_spectrum(1'b1, 1'b0, -1);
        wait_drain("t6_drain");
        check("t6_drops", 66'(drop_count), 66'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
